pc_sequencer: RTL

Parametrised program counter for the processor fetch stage: width-configurable, with sequential increment, absolute jump, signed relative branch, stall, and an optional hardware call/return stack. Drives the instruction-memory address each cycle and takes control strobes from the decode/control unit. Registered output; one update per clock.

---
 rtl/pc_pkg.sv | 45 ++++
 rtl/pc_ret_stack.sv | 79 +++++++
 rtl/pc_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
//   Shared definitions for the fetch-stage program counter.
//   - pc_sel_e    : next-PC source selected for the coming clock edge.
//   - pc_priority : resolves the control strobes into a single pc_sel_e.
//                   The order is stall > ret > call > load > branch > increment.
//                   Any lower-priority strobe that is asserted alongside a
//                   higher one is dropped for that cycle.
// -----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_INC    = 3'd1,
        PC_LOAD   = 3'd2,
        PC_BRANCH = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_sel_e;

    function automatic pc_sel_e pc_priority(
        input logic stall,
        input logic ret,
        input logic call,
        input logic load,
        input logic branch
    );
        pc_sel_e sel;
        if (stall) begin
            sel = PC_HOLD;
        end else if (ret) begin
            sel = PC_RET;
        end else if (call) begin
            sel = PC_CALL;
        end else if (load) begin
            sel = PC_LOAD;
        end else if (branch) begin
            sel = PC_BRANCH;
        end else begin
            sel = PC_INC;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// -----------------------------------------------------------------------------
// pc_ret_stack
//   LIFO of DEPTH entries, each WIDTH bits wide, that holds return addresses
//   for the program counter. It is instantiated only when PC_STACK_EN is
//   defined.
//
//   Ports
//     clk        in  : rising-edge clock
//     reset      in  : synchronous, active-high; empties the stack (the stored
//                      contents are left undefined)
//     push       in  : write push_data on top; ignored while full
//     pop        in  : drop the top entry; ignored while empty; takes priority
//                      over push when both are asserted
//     push_data  in  : value to push
//     top_data   out : current top entry (reads as 0 while empty)
//     count      out : number of valid entries, 0..DEPTH
//     full       out : count == DEPTH
//     empty      out : count == 0
// -----------------------------------------------------------------------------
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             top_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // The write slot is the current count and the top entry sits one below it.
    // Neither index is used when the stack is full (write) or empty (read).
    assign wr_idx = AW'(count_q);
    assign rd_idx = AW'(count_q - CW'(1));

    assign top_data = empty ? '0 : mem_q[rd_idx];
    assign count    = count_q;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end else if (push && !full) begin
            mem_d[wr_idx] = push_data;
            count_d       = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
        // Storage has no reset; entries above count are never observed.
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program counter for the fetch stage. It supports sequential increment,
//   absolute jump, signed relative branch, stall, and an optional hardware
//   call/return stack. pc_out is registered and updates once per rising edge.
//
//   Build option
//     PC_STACK_EN defined   : call pushes PC+1 and jumps; ret pops into PC.
//                             sp, ovf and unf are live.
//     PC_STACK_EN undefined : no stack. call acts as load and ret acts as
//                             increment. sp, ovf and unf are tied to 0.
//
//   Ports
//     clk     in  : rising-edge clock
//     reset   in  : synchronous, active-high; pc_out <= RESET_VEC, stack
//                   emptied, ovf and unf cleared
//     stall   in  : hold PC, stack and flags
//     load    in  : jump to target
//     target  in  : jump/call destination
//     branch  in  : pc_out <= pc_out + offset (offset is relative to the
//                   current PC, not PC+1)
//     offset  in  : signed two's-complement displacement
//     call    in  : push pc_out+1, jump to target
//     ret     in  : pop the return address into pc_out
//     pc_out  out : current PC
//     sp      out : number of valid stack entries
//     ovf     out : sticky flag, set by a call while the stack is full
//     unf     out : sticky flag, set by a ret while the stack is empty
//
//   There is no handshake. Each strobe is a single-cycle level qualifier that
//   is sampled on every rising edge, and its effect shows on pc_out, sp, ovf
//   and unf right after that same edge. Simultaneous strobes are resolved by
//   pc_pkg::pc_priority.
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC   = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               load,
    input  logic [WIDTH-1:0]                   target,
    input  logic                               branch,
    input  logic [WIDTH-1:0]                   offset,
    input  logic                               call,
    input  logic                               ret,
    output logic [WIDTH-1:0]                   pc_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               ovf,
    output logic                               unf
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);

    pc_sel_e          sel;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_br;

    assign sel = pc_priority(stall, ret, call, load, branch);

    // Both adds wrap modulo 2^WIDTH. Because offset is two's complement,
    // the same adder handles forward and backward branches.
    assign pc_inc = pc_q + WIDTH'(1);
    assign pc_br  = pc_q + offset;

`ifdef PC_STACK_EN
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic             stk_push;
    logic             stk_pop;
    logic             stk_full;
    logic             stk_empty;
    logic [WIDTH-1:0] stk_top;
    logic [SPW-1:0]   stk_count;

    // Overflowing calls and underflowing rets leave the stack alone.
    assign stk_push = (sel == PC_CALL) && !stk_full;
    assign stk_pop  = (sel == PC_RET)  && !stk_empty;

    pc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .count     (stk_count),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        case (sel)
            PC_HOLD:   pc_d = pc_q;
            PC_INC:    pc_d = pc_inc;
            PC_LOAD:   pc_d = target;
            PC_BRANCH: pc_d = pc_br;
            PC_CALL: begin
                // The jump is taken even when the return address is lost.
                pc_d = target;
                if (stk_full) begin
                    ovf_d = 1'b1;
                end
            end
            PC_RET: begin
                if (stk_empty) begin
                    // With nothing to return to, this cycle becomes a plain increment.
                    unf_d = 1'b1;
                    pc_d  = pc_inc;
                end else begin
                    pc_d = stk_top;
                end
            end
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign sp  = stk_count;
    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    always_comb begin
        pc_d = pc_q;
        case (sel)
            PC_HOLD:   pc_d = pc_q;
            PC_INC:    pc_d = pc_inc;
            PC_LOAD:   pc_d = target;
            PC_BRANCH: pc_d = pc_br;
            PC_CALL:   pc_d = target;
            PC_RET:    pc_d = pc_inc;
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign sp  = SPW'(0);
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    assign pc_out = pc_q;

endmodule
